// File: rtl/jedro_1_lsu.sv
// Load-store unit for the jedro_1 core: effective-address generation, byte-lane
// formatting, req/gnt/rvalid handshake to data memory and load writeback.
//
// state | meaning
// IDLE  | waiting for a decoder request; misaligned accesses fault here
// REQ   | data_req_o high, data_* held until data_gnt_i
// RESP  | waiting for data_rvalid_i, then writeback (loads) and return
module jedro_1_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      ctrl_valid_i,
  input  logic [3:0]                ctrl_i,
  input  logic [DATA_WIDTH-1:0]     addr_base_i,
  input  logic [11:0]               addr_offset_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
  output logic                      busy_o,
  output logic                      rf_wb_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_dest_o,
  output logic [DATA_WIDTH-1:0]     rf_data_o,
  output logic                      misaligned_load_o,
  output logic                      misaligned_store_o,
  output logic [DATA_WIDTH-1:0]     misaligned_addr_o,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [DATA_WIDTH-1:0]     data_addr_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  input  logic                      data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  ctrl_q;
  logic [1:0]                  off_q;
  logic [REG_ADDR_WIDTH-1:0]   rd_q;
  logic [DATA_WIDTH-1:0]       ea;
  logic                        legal, aligned, accept, fault, done;
  logic [3:0]                  be_d;
  logic [DATA_WIDTH-1:0]       wdata_d, shifted, ld_data;

  assign ea = addr_base_i + {{(DATA_WIDTH-12){addr_offset_i[11]}}, addr_offset_i};

  always_comb begin
    legal = 1'b0;
    case (ctrl_i)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b0101, 4'b1000, 4'b1001, 4'b1010: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned = 1'b0;
    be_d    = 4'b1111;
    wdata_d = wdata_i;
    case (ctrl_i[1:0])
      2'b00: begin
        aligned = 1'b1;
        be_d    = 4'b0001 << ea[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        aligned = ~ea[0];
        be_d    = 4'b0011 << ea[1:0];
        wdata_d = {2{wdata_i[15:0]}};
      end
      2'b10: aligned = (ea[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fault   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_valid_i && legal) begin
          if (aligned) begin
            accept  = 1'b1;
            state_d = REQ;
          end else begin
            fault = 1'b1;
          end
        end
      end
      REQ:  if (data_gnt_i) state_d = RESP;
      RESP: begin
        if (data_rvalid_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign data_req_o = (state_q == REQ);

  // Load data arrives word-aligned; bring the addressed lane down to bit 0.
  assign shifted = data_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (ctrl_q[1:0])
      2'b00:   ld_data = {{(DATA_WIDTH-8){~ctrl_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   ld_data = {{(DATA_WIDTH-16){~ctrl_q[2] & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q            <= IDLE;
      ctrl_q             <= '0;
      off_q              <= '0;
      rd_q               <= '0;
      data_we_o          <= 1'b0;
      data_be_o          <= '0;
      data_addr_o        <= '0;
      data_wdata_o       <= '0;
      rf_wb_o            <= 1'b0;
      rf_dest_o          <= '0;
      rf_data_o          <= '0;
      misaligned_load_o  <= 1'b0;
      misaligned_store_o <= 1'b0;
      misaligned_addr_o  <= '0;
    end else begin
      state_q            <= state_d;
      rf_wb_o            <= 1'b0;
      misaligned_load_o  <= fault & ~ctrl_i[3];
      misaligned_store_o <= fault & ctrl_i[3];
      if (fault) misaligned_addr_o <= ea;
      if (accept) begin
        ctrl_q       <= ctrl_i;
        off_q        <= ea[1:0];
        rd_q         <= regdest_i;
        data_we_o    <= ctrl_i[3];
        data_be_o    <= be_d;
        data_addr_o  <= {ea[DATA_WIDTH-1:2], 2'b00};
        data_wdata_o <= wdata_d;
      end
      if (done && !ctrl_q[3]) begin
        rf_wb_o   <= 1'b1;
        rf_dest_o <= rd_q;
        rf_data_o <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_jedro_1_lsu.sv
// Directed self-checking bench for jedro_1_lsu with hand-computed expectations.
module tb_jedro_1_lsu;
  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        ctrl_valid_i = 1'b0;
  logic [3:0]  ctrl_i = '0;
  logic [31:0] addr_base_i = '0;
  logic [11:0] addr_offset_i = '0;
  logic [31:0] wdata_i = '0;
  logic [4:0]  regdest_i = '0;
  logic        busy_o, rf_wb_o;
  logic [4:0]  rf_dest_o;
  logic [31:0] rf_data_o;
  logic        misaligned_load_o, misaligned_store_o;
  logic [31:0] misaligned_addr_o;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;

  int n_chk = 0;
  int n_fail = 0;

  jedro_1_lsu dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .ctrl_valid_i(ctrl_valid_i), .ctrl_i(ctrl_i),
    .addr_base_i(addr_base_i), .addr_offset_i(addr_offset_i), .wdata_i(wdata_i),
    .regdest_i(regdest_i), .busy_o(busy_o), .rf_wb_o(rf_wb_o), .rf_dest_o(rf_dest_o),
    .rf_data_o(rf_data_o), .misaligned_load_o(misaligned_load_o),
    .misaligned_store_o(misaligned_store_o), .misaligned_addr_o(misaligned_addr_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] b, input logic [11:0] o,
                       input logic [31:0] wd, input logic [4:0] rd);
    ctrl_valid_i = 1'b1; ctrl_i = c; addr_base_i = b; addr_offset_i = o;
    wdata_i = wd; regdest_i = rd;
    step();
    ctrl_valid_i = 1'b0; ctrl_i = '0; addr_base_i = '0; addr_offset_i = '0;
    wdata_i = '0; regdest_i = '0;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr, input logic [3:0] be,
                            input logic we, input logic [31:0] wd);
    chk({tag, "_req"}, {31'd0, data_req_o}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
    chk({tag, "_addr"}, data_addr_o, addr);
    chk({tag, "_be"}, {28'd0, data_be_o}, {28'd0, be});
    chk({tag, "_we"}, {31'd0, data_we_o}, {31'd0, we});
    if (we) chk({tag, "_wdata"}, data_wdata_o, wd);
  endtask

  // Starts in the first REQ cycle, ends in the cycle after rvalid.
  task automatic complete(input string tag, input int gnt_dly, input logic [31:0] rdata,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic we, input logic [31:0] wd);
    for (int i = 0; i < gnt_dly; i++) begin
      expect_req(tag, addr, be, we, wd);
      data_rvalid_i = 1'b1;
      step();
      data_rvalid_i = 1'b0;
    end
    expect_req(tag, addr, be, we, wd);
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, data_req_o}, 32'd0);
    chk({tag, "_busy_resp"}, {31'd0, busy_o}, 32'd1);
    data_rvalid_i = 1'b1; data_rdata_i = rdata;
    step();
    data_rvalid_i = 1'b0; data_rdata_i = '0;
    chk({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic check_wb(input string tag, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, "_wb"}, {31'd0, rf_wb_o}, 32'd1);
    chk({tag, "_dest"}, {27'd0, rf_dest_o}, {27'd0, rd});
    chk({tag, "_data"}, rf_data_o, d);
  endtask

  initial begin
    #3;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_req", {31'd0, data_req_o}, 32'd0);
    chk("rst_addr", data_addr_o, 32'd0);
    chk("rst_rfdata", rf_data_o, 32'd0);
    step();
    rstn_i = 1'b1;
    step();

    // LW 0x1000+4, gnt immediate, wb in cycle 3
    issue(4'b0010, 32'h0000_1000, 12'h004, 32'h0, 5'd5);
    complete("lw", 0, 32'hDEAD_BEEF, 32'h0000_1004, 4'b1111, 1'b0, 32'h0);
    check_wb("lw", 5'd5, 32'hDEAD_BEEF);
    step();
    chk("lw_wb_pulse", {31'd0, rf_wb_o}, 32'd0);
    chk("lw_data_hold", rf_data_o, 32'hDEAD_BEEF);

    issue(4'b0000, 32'h0000_2000, 12'h003, 32'h0, 5'd6);
    complete("lb", 0, 32'h80FF_0000, 32'h0000_2000, 4'b1000, 1'b0, 32'h0);
    check_wb("lb", 5'd6, 32'hFFFF_FF80);
    issue(4'b0100, 32'h0000_2000, 12'h003, 32'h0, 5'd7);
    complete("lbu", 0, 32'h80FF_0000, 32'h0000_2000, 4'b1000, 1'b0, 32'h0);
    check_wb("lbu", 5'd7, 32'h0000_0080);

    // SH with delayed grant; stray rvalid during REQ must be ignored
    issue(4'b1001, 32'h0000_3000, 12'h002, 32'h1234_ABCD, 5'd9);
    complete("sh", 3, 32'h0, 32'h0000_3000, 4'b1100, 1'b1, 32'hABCD_ABCD);
    chk("sh_no_wb", {31'd0, rf_wb_o}, 32'd0);
    chk("sh_rf_hold", rf_data_o, 32'h0000_0080);

    issue(4'b0001, 32'h0000_5000, 12'h002, 32'h0, 5'd10);
    complete("lh", 0, 32'h8001_1234, 32'h0000_5000, 4'b1100, 1'b0, 32'h0);
    check_wb("lh", 5'd10, 32'hFFFF_8001);
    issue(4'b0101, 32'h0000_5000, 12'h002, 32'h0, 5'd11);
    complete("lhu", 0, 32'h8001_1234, 32'h0000_5000, 4'b1100, 1'b0, 32'h0);
    check_wb("lhu", 5'd11, 32'h0000_8001);

    issue(4'b1000, 32'h0000_6000, 12'h001, 32'h0000_00A5, 5'd0);
    complete("sb", 1, 32'h0, 32'h0000_6000, 4'b0010, 1'b1, 32'hA5A5_A5A5);
    chk("sb_no_wb", {31'd0, rf_wb_o}, 32'd0);

    // misaligned LW at 0x4001
    issue(4'b0010, 32'h0000_4000, 12'h001, 32'h0, 5'd1);
    chk("mla_pulse", {31'd0, misaligned_load_o}, 32'd1);
    chk("mla_st", {31'd0, misaligned_store_o}, 32'd0);
    chk("mla_addr", misaligned_addr_o, 32'h0000_4001);
    chk("mla_req", {31'd0, data_req_o}, 32'd0);
    chk("mla_busy", {31'd0, busy_o}, 32'd0);
    step();
    chk("mla_one_cycle", {31'd0, misaligned_load_o}, 32'd0);
    chk("mla_addr_hold", misaligned_addr_o, 32'h0000_4001);
    // misaligned SH at 0x4004 - 1 = 0x4003
    issue(4'b1001, 32'h0000_4004, 12'hFFF, 32'h0, 5'd0);
    chk("msa_pulse", {31'd0, misaligned_store_o}, 32'd1);
    chk("msa_ld", {31'd0, misaligned_load_o}, 32'd0);
    chk("msa_addr", misaligned_addr_o, 32'h0000_4003);
    chk("msa_req", {31'd0, data_req_o}, 32'd0);
    step();
    chk("msa_one_cycle", {31'd0, misaligned_store_o}, 32'd0);

    // address wrap
    issue(4'b0010, 32'hFFFF_FFFC, 12'h008, 32'h0, 5'd12);
    complete("wrap", 0, 32'h1122_3344, 32'h0000_0004, 4'b1111, 1'b0, 32'h0);
    check_wb("wrap", 5'd12, 32'h1122_3344);

    // illegal ctrl ignored
    issue(4'b0110, 32'h0000_7000, 12'h000, 32'h0, 5'd13);
    chk("ill_req", {31'd0, data_req_o}, 32'd0);
    chk("ill_busy", {31'd0, busy_o}, 32'd0);
    chk("ill_mis", {30'd0, misaligned_load_o, misaligned_store_o}, 32'd0);

    // reset while in RESP
    issue(4'b0010, 32'h0000_8000, 12'h000, 32'h0, 5'd14);
    data_gnt_i = 1'b1;
    step();
    data_gnt_i = 1'b0;
    chk("rr_in_resp", {31'd0, busy_o}, 32'd1);
    rstn_i = 1'b0;
    #1;
    chk("rr_busy", {31'd0, busy_o}, 32'd0);
    chk("rr_addr", data_addr_o, 32'd0);
    chk("rr_be", {28'd0, data_be_o}, 32'd0);
    chk("rr_rfdata", rf_data_o, 32'd0);
    chk("rr_misaddr", misaligned_addr_o, 32'd0);
    step();
    rstn_i = 1'b1;
    step();
    chk("rr_no_wb", {31'd0, rf_wb_o}, 32'd0);
    chk("rr_no_exc", {30'd0, misaligned_load_o, misaligned_store_o}, 32'd0);
    issue(4'b0010, 32'h0000_9000, 12'h010, 32'h0, 5'd15);
    complete("rr_lw", 0, 32'hCAFE_F00D, 32'h0000_9010, 4'b1111, 1'b0, 32'h0);
    check_wb("rr_lw", 5'd15, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/jedro_1_lsu.md
Name: jedro_1_lsu

Overview:
Load-store unit for the jedro_1 RV32I core. It sits directly downstream of the decoder, which drives it with the 4-bit LSU control encodings from jedro_1_defines. It computes the effective address, forms byte enables and replicated write data, and runs a req/gnt/rvalid handshake to data memory. Load results are aligned and sign/zero-extended, then returned to the register file with a one-cycle writeback strobe.

Parameters:
DATA_WIDTH, 32, data/address width; only 32 supported
REG_ADDR_WIDTH, 5, register-file address width

Ports:
clk_i  in  1  core clock
rstn_i  in  1  reset; asynchronous assert, active-low
ctrl_valid_i  in  1  request from decoder; sampled only in IDLE
ctrl_i  in  4  LSU_* encoding; bit3 = store, bit2 = unsigned load, bits1:0 = size (00 byte, 01 half, 10 word)
addr_base_i  in  32  rs1 value
addr_offset_i  in  12  signed immediate
wdata_i  in  32  rs2 value, for stores
regdest_i  in  5  rd, for loads
busy_o  out  1  high whenever state != IDLE (combinational)
rf_wb_o  out  1  one-cycle load writeback strobe
rf_dest_o  out  5  rd of the completed load
rf_data_o  out  32  extended load data
misaligned_load_o  out  1  one-cycle pulse
misaligned_store_o  out  1  one-cycle pulse
misaligned_addr_o  out  32  faulting effective address
data_req_o  out  1  memory request
data_gnt_i  in  1  memory grant
data_we_o  out  1  1 = write
data_be_o  out  4  byte enables
data_addr_o  out  32  word-aligned address
data_wdata_o  out  32  write data
data_rvalid_i  in  1  response valid; also sent for stores
data_rdata_i  in  32  read data

Behaviour:
- Reset (rstn_i low, async): state IDLE; every output and internal register is 0. Reset mid-transaction abandons it: no writeback and no exception. The memory must not deliver a stale rvalid after reset.
- Effective address: ea = addr_base_i + sign-extended addr_offset_i, computed modulo 2^32, so wrap-around is allowed.
- Legal ctrl values: 0000, 0001, 0010, 0100, 0101, 1000, 1001, 1010. Any other value with ctrl_valid_i is ignored: no request, no pulse, stays IDLE.
- IDLE, legal ctrl_valid_i, misaligned (half with ea[0]=1, or word with ea[1:0]!=0):
  - Next cycle: misaligned_load_o or misaligned_store_o = 1 for exactly one cycle, with misaligned_addr_o = ea.
  - No memory request; state stays IDLE.
  - misaligned_addr_o holds its value until the next fault.
- IDLE, legal aligned request:
  - Register data_addr_o = {ea[31:2], 2'b00}.
  - Register data_we_o = ctrl[3].
  - data_be_o: byte = 0001 << ea[1:0]; half = 0011 << ea[1:0]; word = 1111.
  - data_wdata_o: byte = {4{wdata_i[7:0]}}; half = {2{wdata_i[15:0]}}; word = wdata_i.
  - Also latch ctrl, ea[1:0] and regdest_i. Go to REQ.
- REQ: data_req_o = 1 and all data_* outputs held stable until data_gnt_i = 1. On gnt → RESP; data_req_o drops the next cycle.
- RESP: wait for data_rvalid_i; the memory never returns rvalid in the same cycle as gnt.
  - On rvalid with a load: next cycle rf_wb_o = 1 for one cycle, with rf_dest_o = latched rd.
  - rf_data_o = (data_rdata_i >> 8*ea[1:0]), truncated to size, then sign-extended (bit2 = 0) or zero-extended (bit2 = 1). Word loads pass through unchanged.
  - On rvalid with a store: no writeback.
  - Either way → IDLE. ctrl_valid_i may be accepted in the same cycle rf_wb_o is high.
- ctrl_valid_i while busy_o = 1 is ignored. The decoder stalls on busy_o.
- rf_dest_o and rf_data_o hold their values between strobes.
- Minimum latency:
  - Load: ctrl_valid at cycle 0, req at 1, gnt at 1, rvalid at 2, rf_wb_o at 3.
  - Store: done at rvalid (cycle 2), with busy_o low at 3.
- data_gnt_i and data_rvalid_i are ignored outside REQ and RESP respectively.

Test Plan:
- LW, base 0x1000, offset +4, rdata 0xDEADBEEF, gnt same cycle as req, rvalid 1 cycle later → data_addr_o = 0x1004, be = 1111, rf_wb_o at cycle 3, rf_data_o = 0xDEADBEEF.
- LB and LBU at ea 0x2003, rdata 0x80FF_0000 → be = 1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH at ea 0x3002 with wdata 0x1234ABCD, gnt delayed 3 cycles → be = 1100, wdata = 0xABCDABCD, data_we_o = 1, outputs stable across the wait, no rf_wb_o.
- LW at ea 0x4001 and SH at ea 0x4003 → one-cycle misaligned_load_o / misaligned_store_o with addr 0x4001 / 0x4003, data_req_o stays 0.
- Base 0xFFFFFFFC, offset +8, word load → ea wraps to 0x00000004, normal completion. ctrl 0110 → no request.
- rstn_i low while in RESP → all outputs 0 immediately; after release no rf_wb_o, and a new LW completes normally.
